// File: rtl/div_iter.sv
// -----------------------------------------------------------------------------
// div_iter : iterative restoring divider for the EX stage (DIV / DIVU).
//
// Produces {remainder, quotient} after WIDTH iteration cycles.
// Signed operands are divided as magnitudes, and the signs are applied once
// at the end. busy_o feeds the pipeline stall request.
//
// Optional feature macro: DIV_ZERO_FLAG_EN
//   defined   -> extra output divzero_o, raised with ready_o for a divide by 0
//   undefined -> no divzero_o port; a divide by 0 is seen as result_o == 0
//
// Handshake: EX raises start_i and holds it until it sees ready_o. The
// operands are sampled only in the cycle the divide is accepted. ready_o and
// result_o stay valid for as long as start_i stays high. Dropping start_i for
// at least one cycle returns the unit to IDLE, and only then can a new divide
// start. annul_i only aborts a divide while it is iterating.
//
// dbg_state_o exposes the FSM state for debug and checkers:
//   0 = IDLE, 1 = BYZERO, 2 = ON, 3 = END.
// -----------------------------------------------------------------------------
module div_iter #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               signed_div_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic               start_i,
    input  logic               annul_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o,
    output logic               busy_o,
`ifdef DIV_ZERO_FLAG_EN
    output logic               divzero_o,
`endif
    output logic [1:0]         dbg_state_o
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BYZERO = 2'd1,
        ST_ON     = 2'd2,
        ST_END    = 2'd3
    } state_t;

    state_t           state, state_nxt;

    logic [WIDTH-1:0] rem_q;      // partial remainder
    logic [WIDTH-1:0] quo_q;      // dividend shifting out / quotient shifting in
    logic [WIDTH-1:0] dvs_q;      // divisor magnitude
    logic             neg_quo_q;  // quotient must be negated at the end
    logic             neg_rem_q;  // remainder takes the dividend's sign
    logic [CW-1:0]    cnt_q;

    logic             accept_zero;
    logic             accept_div;
    logic             last_step;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] rem_nxt;
    logic [WIDTH-1:0] quo_nxt;
    logic [WIDTH-1:0] quo_fix;
    logic [WIDTH-1:0] rem_fix;

    // A request is taken only from IDLE, and only when it is not being annulled.
    assign accept_zero = (state == ST_IDLE) && start_i && !annul_i
                         && (opdata2_i == '0);
    assign accept_div  = (state == ST_IDLE) && start_i && !annul_i
                         && (opdata2_i != '0);
    assign last_step   = (cnt_q == CW'(WIDTH - 1));

    // Take operand magnitudes. A value of -2^(W-1) maps onto itself, which is
    // still the correct unsigned magnitude.
    always_comb begin
        abs_a = opdata1_i;
        abs_b = opdata2_i;
        if (signed_div_i && opdata1_i[WIDTH-1]) begin
            abs_a = WIDTH'(0) - opdata1_i;
        end
        if (signed_div_i && opdata2_i[WIDTH-1]) begin
            abs_b = WIDTH'(0) - opdata2_i;
        end
    end

    // One restoring step: shift {rem,quo} left, then trial-subtract the divisor.
    always_comb begin
        trial   = {rem_q, quo_q[WIDTH-1]} - {1'b0, dvs_q};
        rem_nxt = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
        quo_nxt = {quo_q[WIDTH-2:0], 1'b0};
        if (!trial[WIDTH]) begin
            rem_nxt = trial[WIDTH-1:0];
            quo_nxt = {quo_q[WIDTH-2:0], 1'b1};
        end
    end

    // Apply the signs to the final step's quotient and remainder.
    always_comb begin
        quo_fix = neg_quo_q ? (WIDTH'(0) - quo_nxt) : quo_nxt;
        rem_fix = neg_rem_q ? (WIDTH'(0) - rem_nxt) : rem_nxt;
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (accept_zero) begin
                    state_nxt = ST_BYZERO;
                end else if (accept_div) begin
                    state_nxt = ST_ON;
                end
            end
            ST_ON: begin
                if (annul_i) begin
                    state_nxt = ST_IDLE;
                end else if (last_step) begin
                    state_nxt = ST_END;
                end
            end
            ST_BYZERO: begin
                state_nxt = ST_END;
            end
            ST_END: begin
                if (!start_i) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // FSM outputs. busy_o is raised in the same cycle a start is accepted, so
    // the stall takes effect at once. It is held low while reset is applied.
    always_comb begin
        busy_o      = 1'b0;
        dbg_state_o = state;
        if (rst) begin
            case (state)
                ST_IDLE:   busy_o = accept_zero || accept_div;
                ST_BYZERO: busy_o = 1'b1;
                ST_ON:     busy_o = 1'b1;
                default:   busy_o = 1'b0;
            endcase
        end
    end

    // Datapath: latch operands on accept, iterate in ON, and hold the result in END.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            cnt_q     <= '0;
            result_o  <= '0;
            ready_o   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept_div) begin
                        rem_q     <= '0;
                        quo_q     <= abs_a;
                        dvs_q     <= abs_b;
                        neg_quo_q <= signed_div_i
                                     && (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
                        neg_rem_q <= signed_div_i && opdata1_i[WIDTH-1];
                        cnt_q     <= '0;
                    end
                end
                ST_ON: begin
                    if (!annul_i) begin
                        rem_q <= rem_nxt;
                        quo_q <= quo_nxt;
                        cnt_q <= cnt_q + CW'(1);
                        if (last_step) begin
                            result_o <= {rem_fix, quo_fix};
                            ready_o  <= 1'b1;
                        end
                    end
                end
                ST_BYZERO: begin
                    result_o <= '0;
                    ready_o  <= 1'b1;
                end
                ST_END: begin
                    if (!start_i) begin
                        result_o <= '0;
                        ready_o  <= 1'b0;
                    end
                end
                default: begin
                    ready_o <= 1'b0;
                end
            endcase
        end
    end

`ifdef DIV_ZERO_FLAG_EN
    // The divide-by-zero flag rises with ready_o out of BYZERO and falls on leaving END.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            divzero_o <= 1'b0;
        end else if (state == ST_BYZERO) begin
            divzero_o <= 1'b1;
        end else if ((state == ST_END) && !start_i) begin
            divzero_o <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_div_iter.sv
// -----------------------------------------------------------------------------
// tb_div_iter : directed vectors for div_iter (WIDTH = 32), plus hand-written
// sequences for annul, reset and the hold-in-END corner cases.
// -----------------------------------------------------------------------------
module tb_div_iter;

    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           signed_div = 1'b0;
    logic [W-1:0]   op1 = '0;
    logic [W-1:0]   op2 = '0;
    logic           start = 1'b0;
    logic           annul = 1'b0;
    logic [2*W-1:0] result;
    logic           ready;
    logic           busy;
    logic [1:0]     dbg_state;
`ifdef DIV_ZERO_FLAG_EN
    logic           divzero;
`endif

    int n_checks = 0;
    int n_errors = 0;

    logic [2*W-1:0] exp_q[$];

    typedef struct {
        logic         sgn;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        int           lat;
    } vec_t;

    localparam int NV = 12;
    vec_t vecs[NV];

    div_iter #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div),
        .opdata1_i    (op1),
        .opdata2_i    (op2),
        .start_i      (start),
        .annul_i      (annul),
        .result_o     (result),
        .ready_o      (ready),
        .busy_o       (busy),
`ifdef DIV_ZERO_FLAG_EN
        .divzero_o    (divzero),
`endif
        .dbg_state_o  (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- driver ----------------
    // Applies one vector, with start held through 3 extra END cycles.
    task automatic run_vec(input vec_t v);
        logic [2*W-1:0] exp;
        int n;
        exp_q.push_back({v.r, v.q});
        signed_div = v.sgn;
        op1        = v.a;
        op2        = v.b;
        start      = 1'b1;
        #1;
        check("busy_on_accept", busy, 1);
        tick();
        n = 1;
        check("busy_after_accept", busy, 1);
        // These changes must be ignored once the divide has been accepted.
        op1        = $urandom;
        op2        = $urandom_range(0, 3);
        signed_div = ~signed_div;
        while (!ready && n < 100) begin
            tick();
            n++;
        end
        check("ready_rise", ready, 1);
        check("latency", n, v.lat);
        exp = exp_q.pop_front();
        check("result", result, exp);
`ifdef DIV_ZERO_FLAG_EN
        check("divzero", divzero, (v.b == 0) ? 1 : 0);
`endif
        repeat (3) tick();
        check("hold_ready", ready, 1);
        check("hold_result", result, exp);
        check("hold_busy", busy, 0);
        check("hold_state", dbg_state, 3);
        start = 1'b0;
        tick();
        check("drop_ready", ready, 0);
        check("drop_result", result, 0);
        check("drop_state", dbg_state, 0);
`ifdef DIV_ZERO_FLAG_EN
        check("drop_divzero", divzero, 0);
`endif
    endtask

    // ---------------- test ----------------
    initial begin
        int seen;
        vecs[0]  = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          33};
        vecs[1]  = '{1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  33};
        vecs[2]  = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          33};
        vecs[3]  = '{1'b0, 32'h0000_1234,  32'd0,          32'd0,          32'd0,          2};
        vecs[4]  = '{1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          33};
        vecs[5]  = '{1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          32'd0,          33};
        vecs[6]  = '{1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          33};
        vecs[7]  = '{1'b1, 32'hFFFF_FFF9,  32'hFFFF_FFFE,  32'd3,          32'hFFFF_FFFF,  33};
        vecs[8]  = '{1'b0, 32'd5,          32'd10,         32'd0,          32'd5,          33};
        vecs[9]  = '{1'b0, 32'hFFFF_FFF9,  32'd2,          32'h7FFF_FFFC,  32'd1,          33};
        vecs[10] = '{1'b1, 32'hFFFF_FFF9,  32'd0,          32'd0,          32'd0,          2};
        vecs[11] = '{1'b0, 32'h1234_5678,  32'h0000_0100,  32'h0012_3456,  32'h0000_0078,  33};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_result", result, 0);
        check("rst_ready", ready, 0);
        check("rst_busy", busy, 0);
        check("rst_state", dbg_state, 0);
        rst = 1'b1;
        tick();

        // Table-driven vectors
        for (int i = 0; i < NV; i++) begin
            run_vec(vecs[i]);
        end

        // Annul mid-divide: no result, next divide is clean
        signed_div = 1'b0; op1 = 32'd1000; op2 = 32'd3; start = 1'b1;
        repeat (10) tick();
        check("annul_busy_before", busy, 1);
        annul = 1'b1; start = 1'b0;
        tick();
        check("annul_busy", busy, 0);
        check("annul_state", dbg_state, 0);
        annul = 1'b0;
        seen = 0;
        repeat (40) begin
            tick();
            if (ready) seen++;
        end
        check("annul_no_ready", seen, 0);
        run_vec('{1'b0, 32'd1000, 32'd3, 32'd333, 32'd1, 33});

        // annul_i is ignored in BYZERO and in END
        signed_div = 1'b0; op1 = 32'd9; op2 = 32'd0; start = 1'b1;
        tick();
        check("byz_state", dbg_state, 1);
        annul = 1'b1;
        tick();
        check("byz_annul_ready", ready, 1);
        check("byz_annul_result", result, 0);
        tick();
        check("end_annul_ready", ready, 1);
        check("end_annul_state", dbg_state, 3);
        annul = 1'b0; start = 1'b0;
        tick();
        check("byz_drop_ready", ready, 0);

        // Reset asserted mid-divide
        signed_div = 1'b0; op1 = 32'd100; op2 = 32'd7; start = 1'b1;
        repeat (5) tick();
        check("mid_busy", busy, 1);
        rst = 1'b0;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_ready", ready, 0);
        check("mid_rst_state", dbg_state, 0);
        start = 1'b0;
        tick();
        rst = 1'b1;
        tick();

        // Reset asserted while a result is held in END
        signed_div = 1'b1; op1 = 32'hFFFF_FFF9; op2 = 32'd2; start = 1'b1;
        seen = 0;
        tick();
        while (!ready && seen < 100) begin
            tick();
            seen++;
        end
        check("end_before_rst_result", result, 64'hFFFF_FFFF_FFFF_FFFD);
        rst = 1'b0;
        #1;
        check("end_rst_ready", ready, 0);
        check("end_rst_result", result, 0);
        check("end_rst_state", dbg_state, 0);
        start = 1'b0;
        tick();
        rst = 1'b1;
        tick();

        // Operation after reset
        run_vec('{1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 33});

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
